core_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32 NPC datapath.
- Drives instruction fetch, latches decoder control flags, and runs the memory access.
- Generates one-cycle write-back strobes for the GPR file, CSR file and PC.
- Sits between the IFU/LSU bus handshakes and the decoder outputs.
- Also provides retire counting, a halt on trap, and a bus-timeout error stop.

---
 rtl/core_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_core_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV32 NPC datapath: fetch, decode-flag capture, memory access,
// single-cycle write-back strobes, retire counting and terminal halt/bus-error stops.
module core_seq_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req_o,
    input  logic             ifu_ack_i,
    input  logic             ifu_err_i,
    output logic             inst_latch_o,
    input  logic             dec_w_en_i,
    input  logic             dec_w_csr_en_i,
    input  logic             dec_mem_rd_en_i,
    input  logic             dec_mem_wr_en_i,
    output logic             lsu_req_o,
    output logic             lsu_we_o,
    input  logic             lsu_ack_i,
    input  logic             lsu_err_i,
    output logic             gpr_we_o,
    output logic             csr_we_o,
    output logic             pc_we_o,
    input  logic             halt_req_i,
    output logic             halted_o,
    output logic             bus_err_o,
    output logic [2:0]       state_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] ToLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StError  = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic             w_en_q, w_en_d;
    logic             csr_en_q, csr_en_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            to_cnt_q <= '0;
            w_en_q   <= 1'b0;
            csr_en_q <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            halt_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            w_en_q   <= w_en_d;
            csr_en_q <= csr_en_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            halt_q   <= halt_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        w_en_d       = w_en_q;
        csr_en_d     = csr_en_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        // Halt is only recorded here; it takes effect at the next write-back.
        halt_d       = halt_q | (halt_req_i && state_q != StHalt && state_q != StError);
        ifu_req_o    = 1'b0;
        inst_latch_o = 1'b0;
        lsu_req_o    = 1'b0;
        lsu_we_o     = 1'b0;
        gpr_we_o     = 1'b0;
        csr_we_o     = 1'b0;
        pc_we_o      = 1'b0;
        retire_o     = 1'b0;
        halted_o     = 1'b0;
        bus_err_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                state_d  = StFetch;
            end
            StFetch: begin
                ifu_req_o = 1'b1;
                if (ifu_err_i) begin
                    state_d = StError;
                end else if (ifu_ack_i) begin
                    inst_latch_o = 1'b1;
                    state_d      = StDecode;
                end else if (to_cnt_q == ToLast) begin
                    state_d = StError;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StDecode: begin
                w_en_d   = dec_w_en_i;
                csr_en_d = dec_w_csr_en_i;
                rd_d     = dec_mem_rd_en_i;
                wr_d     = dec_mem_wr_en_i;
                state_d  = StExec;
            end
            StExec: begin
                to_cnt_d = '0;
                state_d  = (rd_q || wr_q) ? StMem : StWb;
            end
            StMem: begin
                lsu_req_o = 1'b1;
                lsu_we_o  = wr_q;
                if (lsu_err_i) begin
                    state_d = StError;
                end else if (lsu_ack_i) begin
                    state_d = StWb;
                end else if (to_cnt_q == ToLast) begin
                    state_d = StError;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StWb: begin
                pc_we_o  = 1'b1;
                retire_o = 1'b1;
                gpr_we_o = w_en_q;
                csr_we_o = csr_en_q;
                cnt_d    = cnt_q + 1'b1;
                to_cnt_d = '0;
                state_d  = (halt_q || halt_req_i) ? StHalt : StFetch;
            end
            StHalt:  halted_o = 1'b1;
            StError: bus_err_o = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    assign state_o      = state_q;
    assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: randomized instruction stream against a cycle-count model,
// plus directed halt, timeout, bus-error and asynchronous-reset scenarios.
module tb_core_seq_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifu_req, ifu_ack, ifu_err, inst_latch;
    logic          dec_w_en, dec_w_csr_en, dec_mem_rd_en, dec_mem_wr_en;
    logic          lsu_req, lsu_we, lsu_ack, lsu_err;
    logic          gpr_we, csr_we, pc_we, halt_req, halted, bus_err, retire;
    logic [2:0]    state;
    logic [CW-1:0] retire_cnt;

    core_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_o      (ifu_req),
        .ifu_ack_i      (ifu_ack),
        .ifu_err_i      (ifu_err),
        .inst_latch_o   (inst_latch),
        .dec_w_en_i     (dec_w_en),
        .dec_w_csr_en_i (dec_w_csr_en),
        .dec_mem_rd_en_i(dec_mem_rd_en),
        .dec_mem_wr_en_i(dec_mem_wr_en),
        .lsu_req_o      (lsu_req),
        .lsu_we_o       (lsu_we),
        .lsu_ack_i      (lsu_ack),
        .lsu_err_i      (lsu_err),
        .gpr_we_o       (gpr_we),
        .csr_we_o       (csr_we),
        .pc_we_o        (pc_we),
        .halt_req_i     (halt_req),
        .halted_o       (halted),
        .bus_err_o      (bus_err),
        .state_o        (state),
        .retire_o       (retire),
        .retire_cnt_o   (retire_cnt)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: cycle 0 is IDLE, cycle 1 the first FETCH.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int wb;
        bit gpr;
        bit csr;
        bit st;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   next_s;
    int   model_cnt;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != t) chk("wait_cyc", cyc, t);
    endtask

    task automatic clear_inputs();
        ifu_ack = 0; ifu_err = 0; lsu_ack = 0; lsu_err = 0; halt_req = 0;
        dec_w_en = 0; dec_w_csr_en = 0; dec_mem_rd_en = 0; dec_mem_wr_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        #1;
        chk("rst_state", state, 0);
        chk("rst_outs", {ifu_req, inst_latch, lsu_req, lsu_we, gpr_we, csr_we, pc_we,
                         halted, bus_err, retire}, 0);
        chk("rst_cnt", retire_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        q.delete();
        next_s = 1;
        model_cnt = 0;
    endtask

    // kind: 0 ALU, 1 load, 2 store, 3 CSR op, 4 no write-back
    task automatic run_insn(input int kind, input int fw, input int mw, input bit halt_mem);
        bit   w = 0, c = 0, rd = 0, wr = 0;
        int   s, wb, m0;
        exp_t e;
        case (kind)
            0: w = 1;
            1: begin rd = 1; w = 1; end
            2: wr = 1;
            3: begin c = 1; w = 1'($urandom_range(0, 1)); end
            default: ;
        endcase
        s  = next_s;
        m0 = s + fw + 3;
        wb = m0 + ((rd | wr) ? mw + 1 : 0);
        e.wb = wb; e.gpr = w; e.csr = c; e.st = wr; e.cnt = model_cnt % (1 << CW);
        q.push_back(e);
        model_cnt++;
        next_s = wb + 1;

        wait_cyc(s + fw);
        ifu_ack = 1;
        dec_w_en = w; dec_w_csr_en = c; dec_mem_rd_en = rd; dec_mem_wr_en = wr;
        #1 chk("inst_latch", inst_latch, 1);
        @(negedge clk);
        ifu_ack = 0;
        @(negedge clk);
        // Decoder lines change after DECODE; the latched copy must be used.
        {dec_w_en, dec_w_csr_en, dec_mem_rd_en, dec_mem_wr_en} = 4'($urandom_range(0, 15));
        if (rd | wr) begin
            if (halt_mem) begin
                wait_cyc(m0);
                halt_req = 1;
                @(negedge clk);
                halt_req = 0;
            end
            wait_cyc(m0 + mw);
            lsu_ack = 1;
            @(negedge clk);
            lsu_ack = 0;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (retire) begin
                    if (q.size() == 0) begin
                        chk("unexpected_retire", retire, 0);
                    end else begin
                        e = q.pop_front();
                        chk("wb_cycle", cyc, e.wb);
                        chk("gpr_we", gpr_we, e.gpr);
                        chk("csr_we", csr_we, e.csr);
                        chk("pc_we", pc_we, 1);
                        chk("retire_cnt", retire_cnt, e.cnt);
                    end
                end else begin
                    chk("stray_strobe", {gpr_we, csr_we, pc_we}, 0);
                end
                if (lsu_req && q.size() != 0) chk("lsu_we", lsu_we, q[0].st);
            end
        end
    endtask

    initial begin
        int s;
        clear_inputs();
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        do_reset();
        run_insn(0, 0, 0, 0);
        wait_cyc(5);
        chk("alu_then_fetch", state, 1);
        chk("alu_cnt", retire_cnt, 1);
        run_insn(1, 0, 2, 0);
        run_insn(2, 1, 0, 0);
        run_insn(3, 0, 0, 0);
        repeat (20) run_insn($urandom_range(0, 4), $urandom_range(0, TO - 1),
                             $urandom_range(0, TO - 1), 0);
        wait_cyc(next_s);
        chk("cnt_wrap", retire_cnt, model_cnt % (1 << CW));

        // Halt requested mid-MEM: instruction still retires, then HALT.
        run_insn(1, 0, 2, 1);
        wait_cyc(next_s);
        chk("halt_state", state, 6);
        chk("halted", halted, 1);
        repeat (3) begin
            @(negedge clk);
            chk("halt_no_req", {ifu_req, lsu_req}, 0);
        end

        // Fetch timeout.
        do_reset();
        wait_cyc(TO);
        chk("to_fetch", state, 1);
        wait_cyc(TO + 1);
        chk("to_state", state, 7);
        chk("to_bus_err", bus_err, 1);
        chk("to_ifu_req", ifu_req, 0);
        halt_req = 1;
        @(negedge clk);
        halt_req = 0;
        @(negedge clk);
        chk("err_ignores_halt", {state, halted}, {3'd7, 1'b0});

        // Simultaneous lsu ack and error.
        do_reset();
        run_insn(0, 1, 0, 0);
        s = next_s;
        wait_cyc(s);
        ifu_ack = 1; dec_mem_rd_en = 1; dec_w_en = 1;
        @(negedge clk);
        ifu_ack = 0;
        wait_cyc(s + 3);
        chk("mem_req", lsu_req, 1);
        lsu_ack = 1; lsu_err = 1;
        @(negedge clk);
        clear_inputs();
        chk("ack_err_state", state, 7);
        chk("ack_err_bus_err", bus_err, 1);
        chk("ack_err_lsu_req", lsu_req, 0);
        repeat (2) @(negedge clk);
        chk("ack_err_cnt", retire_cnt, model_cnt);

        // Fetch error beats simultaneous ack.
        do_reset();
        wait_cyc(2);
        ifu_err = 1; ifu_ack = 1;
        #1 chk("err_no_latch", inst_latch, 0);
        @(negedge clk);
        clear_inputs();
        chk("ifu_err_state", state, 7);

        // Asynchronous reset while waiting in MEM.
        do_reset();
        run_insn(2, 0, 0, 0);
        s = next_s;
        wait_cyc(s);
        ifu_ack = 1; dec_mem_rd_en = 1; dec_w_en = 1;
        @(negedge clk);
        ifu_ack = 0;
        wait_cyc(s + 4);
        chk("mem_wait_req", lsu_req, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_lsu_req", lsu_req, 0);
        chk("arst_state", state, 0);
        chk("arst_cnt", retire_cnt, 0);
        q.delete();
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        next_s = 1;
        model_cnt = 0;
        @(negedge clk);
        chk("arst_refetch", {state, ifu_req}, {3'd1, 1'b1});
        run_insn(0, 0, 0, 0);
        wait_cyc(next_s);

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
